// File: rtl/vfd_pwm_multi_if.sv
// vfd_pwm_multi_if: control/status bundle between the VFD top/HMI and the multi-phase PWM generator
// Ports (master = controller side, slave = generator side):
//   pluse_ms  1-clk tick every 1 ms          (master -> slave)
//   en        run request, 0 = ramp to stop  (master -> slave)
//   freq_tgt  target frequency word          (master -> slave)
//   pwm       high-side PWM per channel      (slave -> master)
//   pwm_n     low-side PWM per channel       (slave -> master)
//   freq_cur  current ramped frequency word  (slave -> master)
//   at_speed  running at the requested speed (slave -> master)
interface vfd_pwm_multi_if #(
  parameter int CH = 3,
  parameter int FREQ_W = 10
);
  logic pluse_ms;
  logic en;
  logic [FREQ_W-1:0] freq_tgt;
  logic [CH-1:0] pwm;
  logic [CH-1:0] pwm_n;
  logic [FREQ_W-1:0] freq_cur;
  logic at_speed;
  modport master (output pluse_ms, en, freq_tgt, input pwm, pwm_n, freq_cur, at_speed);
  modport slave (input pluse_ms, en, freq_tgt, output pwm, pwm_n, freq_cur, at_speed);
endinterface

// File: rtl/vfd_pwm_multi.sv
// vfd_pwm_multi: CH-phase triangle-modulated PWM with rate-limited frequency ramp
// Ports: clk_sys (system clock), rst_n (async active-low reset),
//   bus (vfd_pwm_multi_if.slave: pluse_ms, en, freq_tgt in; pwm, pwm_n, freq_cur, at_speed out)
// Optional: define VFD_DEADTIME_EN to insert DEAD_CYC low clocks on every raw PWM edge.
module vfd_pwm_multi #(
  parameter int CH = 3,
  parameter int FREQ_W = 10,
  parameter int ACC_W = 24,
  parameter int CAR_W = 8,
  parameter int RAMP_STEP = 1,
  parameter int DEAD_CYC = 4
) (
  input logic clk_sys,
  input logic rst_n,
  vfd_pwm_multi_if.slave bus
);
  localparam logic [FREQ_W-1:0] STEP = FREQ_W'(RAMP_STEP);
  logic [FREQ_W-1:0] freq, tgt, diff_up, diff_dn, freq_nxt;
  logic run;
  logic [ACC_W-1:0] acc;
  logic [CAR_W-1:0] car;
  logic [CH-1:0] pwm_v, pwm_n_v;
  // Step toward the effective target only on a ms tick, clamped so it never overshoots.
  always_comb begin
    tgt = bus.en ? bus.freq_tgt : '0;
    diff_up = tgt - freq;
    diff_dn = freq - tgt;
    freq_nxt = !bus.pluse_ms ? freq :
               freq < tgt ? freq + (diff_up < STEP ? diff_up : STEP) :
               freq > tgt ? freq - (diff_dn < STEP ? diff_dn : STEP) : freq;
  end
  // run tracks freq!=0 in lockstep; acc clears while stopped so restarts are phase-aligned.
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      freq <= '0;
      run <= 1'b0;
      acc <= '0;
      car <= '0;
    end else begin
      freq <= freq_nxt;
      run <= freq_nxt != '0;
      acc <= run ? acc + ACC_W'(freq) : '0;
      car <= car + CAR_W'(1);
    end
  for (genvar k = 0; k < CH; k++) begin : g_ch
    localparam logic [ACC_W-1:0] PH_OFF = ACC_W'(k * ((64'd1 << ACC_W) / CH));
    logic [CAR_W:0] m;
    logic [CAR_W-1:0] tri_v, duty;
    logic raw, p, pn;
    // Top CAR_W+1 phase bits fold into a triangle: rising half as-is, falling half inverted.
    assign m = (CAR_W+1)'((acc + PH_OFF) >> (ACC_W - CAR_W - 1));
    assign tri_v = m[CAR_W] ? ~m[CAR_W-1:0] : m[CAR_W-1:0];
    assign raw = run && (car < duty);
    // Duty only changes at carrier wrap so each period compares against one stable value.
    always_ff @(posedge clk_sys or negedge rst_n)
      if (!rst_n) duty <= '0;
      else if (car == '1) duty <= tri_v;
`ifdef VFD_DEADTIME_EN
    localparam int DW = $clog2(DEAD_CYC + 1);
    logic [DW-1:0] dc;
    logic raw_q;
    // Any raw edge (re)loads the window; both sides stay low until it drains.
    always_ff @(posedge clk_sys or negedge rst_n)
      if (!rst_n) begin
        dc <= '0;
        raw_q <= 1'b0;
        p <= 1'b0;
        pn <= 1'b0;
      end else begin
        raw_q <= raw;
        dc <= !run ? '0 : raw != raw_q ? DW'(DEAD_CYC - 1) : dc != '0 ? dc - DW'(1) : dc;
        p <= run && raw == raw_q && dc == '0 && raw;
        pn <= run && raw == raw_q && dc == '0 && !raw;
      end
`else
    always_ff @(posedge clk_sys or negedge rst_n)
      if (!rst_n) begin
        p <= 1'b0;
        pn <= 1'b0;
      end else begin
        p <= raw;
        pn <= run && !raw;
      end
`endif
    assign pwm_v[k] = p;
    assign pwm_n_v[k] = pn;
  end
  assign bus.pwm = pwm_v;
  assign bus.pwm_n = pwm_n_v;
  assign bus.freq_cur = freq;
  assign bus.at_speed = bus.en && run && (freq == bus.freq_tgt);
endmodule

// File: doc/vfd_pwm_multi.md
Name: vfd_pwm_multi

Overview:
Parametrised multi-phase successor to the single-output VFD PWM generator. Produces CH phase-offset PWM channels plus complementary outputs, using triangle modulation against a free-running carrier. Output frequency ramps toward a target at a limited rate, paced by the ms tick from the clock/reset block. Sits under the VFD top; the HMI block drives its target frequency.

Parameters:
CH, 3, number of PWM channels (1..8); phase offset between channels is 2^ACC_W/CH.
FREQ_W, 10, width of target/current frequency words.
ACC_W, 24, phase accumulator width; f_out = freq_cur*f_clk/2^ACC_W.
CAR_W, 8, carrier counter width; carrier period 2^CAR_W clocks.
RAMP_STEP, 1, max |freq_cur change| per pluse_ms tick.
DEAD_CYC, 4, dead-time clocks (used only with optional feature).

Ports:
clk_sys  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
pluse_ms  input  1  one-clk_sys-wide tick every 1 ms
en  input  1  run request; 0 = ramp down to stop
freq_tgt  input  FREQ_W  target frequency word
pwm  output  CH  high-side PWM, bit k = channel k
pwm_n  output  CH  low-side/complementary PWM
freq_cur  output  FREQ_W  current ramped frequency word
at_speed  output  1  freq_cur==freq_tgt and freq_cur!=0 and en

Behaviour:
- Reset (async, rst_n=0): pwm=0, pwm_n=0, freq_cur=0, at_speed=0, accumulator=0, carrier=0, duty latches=0, dead counters=0.
- Ramp target: tgt_eff = en ? freq_tgt : 0. On each pluse_ms: if freq_cur<tgt_eff, add min(RAMP_STEP, diff); if greater, subtract min(RAMP_STEP, diff); equal = hold. Never overshoots. freq_tgt change mid-ramp redirects at the next tick. No change between ticks.
- run = (freq_cur!=0). Registered, same cycle freq_cur updates.
- Accumulator: when run, acc <= acc + freq_cur (zero-extended, wraps mod 2^ACC_W) every clock. When !run, acc <= 0, so a restart is phase-aligned.
- Channel phase: ph_k = acc + k*floor(2^ACC_W/CH) mod 2^ACC_W.
- Triangle: m = ph_k[ACC_W-1 -: CAR_W+1]; tri_k = m[CAR_W] ? ~m[CAR_W-1:0] : m[CAR_W-1:0]. Range 0..2^CAR_W-1.
- Carrier: car counts up every clock, wraps 2^CAR_W-1 -> 0. Runs regardless of run.
- Duty latch: on the clock where car==2^CAR_W-1, duty_k <= tri_k. Duty is stable for a whole carrier period (glitch-free update).
- Raw compare: raw_k = run && (car < duty_k). duty=0 gives constant low; duty=2^CAR_W-1 gives high for 2^CAR_W-1 of 2^CAR_W clocks.
- pwm registered from raw: 1 clk_sys latency from car/duty to pin.
- pwm_n (no dead time): registered, pwm_n_k = run && !raw_k. Both outputs are low whenever !run.
- Stop: when en drops, freq_cur ramps to 0. On the clock after freq_cur reaches 0, all outputs go low and acc clears.
- Reset mid-operation: outputs go to 0 immediately. After release, the ramp restarts from 0.

Optional Feature:
VFD_DEADTIME_EN
- Defined: per channel, on any edge of raw_k, both pwm_k and pwm_n_k are driven low for DEAD_CYC clocks, then the output matching the new raw level asserts. An edge inside the dead window restarts the count. pwm_k and pwm_n_k are never high together, including for one cycle. When !run, both are low and the dead counter is 0.
- Undefined: complementary behaviour as in Behaviour with no dead band; DEAD_CYC is ignored.

Test Plan:
- Reset: hold rst_n=0, en=1, freq_tgt=100 -> pwm=0, pwm_n=0, freq_cur=0, at_speed=0 throughout. Release -> freq_cur=1 after first pluse_ms.
- Ramp: RAMP_STEP=2, freq_tgt=5, en=1, ticks every 1000 clk -> freq_cur 2,4,5 on successive ticks. at_speed=1 after third tick, no overshoot.
- Redirect/stop: at freq_cur=40, set freq_tgt=10 -> decrements by RAMP_STEP per tick to 10. Then en=0 -> reaches 0, next clock pwm=pwm_n=0 and acc=0.
- Duty extremes: force duty_k=0 -> pwm_k never high. Force duty_k=255 (CAR_W=8) -> pwm_k high 255 of every 256 clocks, low exactly one clock. Check 1-clk latency after car wrap.
- Phase: CH=3, steady freq_cur=64 -> pwm channels have identical duty sequences offset by 1/3 of the output period (±1 carrier period).
- Dead time (VFD_DEADTIME_EN, DEAD_CYC=4): on every raw edge, pwm and pwm_n both low for exactly 4 clocks. Assertion pwm&pwm_n==0 holds for the whole run.
